// File: rtl/maze_pkg.sv
// Shared types for the maze path replay datapath: move directions, replay FSM
// states and the step counter width.
package maze_pkg;

    localparam int unsigned STEP_W = 8;

    // Direction codes as they arrive from the path queue.
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        APPLY = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } replay_state_t;

endpackage

// File: rtl/path_replayer_if.sv
// Bus bundle between the replayer, the direction queue and the position consumer.
//   q_empty/q_data/q_deq     : direction queue side (q_data valid the cycle after q_deq)
//   pos_valid/pos_ready/pos_x/pos_y : position stream toward the visualiser
// master modport = replayer, slave modport = queue + consumer.
interface path_replayer_if #(
    parameter int unsigned COORD_W = 4
);
    logic               q_empty;
    logic [1:0]         q_data;
    logic               q_deq;
    logic               pos_valid;
    logic               pos_ready;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;

    modport master (
        input  q_empty, q_data, pos_ready,
        output q_deq, pos_valid, pos_x, pos_y
    );

    modport slave (
        output q_empty, q_data, pos_ready,
        input  q_deq, pos_valid, pos_x, pos_y
    );
endinterface

// File: rtl/pos_step.sv
// Combinational single-move step on the grid.
//   dir    : move direction
//   x, y   : current position
//   nx, ny : position after the move, wrapping modulo 2**COORD_W
//   oob    : the move would leave the grid (under/overflow of x or y)
module pos_step
    import maze_pkg::*;
#(
    parameter int unsigned COORD_W = 4
) (
    input  dir_t               dir,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] nx,
    output logic [COORD_W-1:0] ny,
    output logic               oob
);

    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    always_comb begin
        nx  = x;
        ny  = y;
        oob = 1'b0;
        case (dir)
            DIR_UP: begin
                ny  = y - COORD_W'(1);
                oob = (y == '0);
            end
            DIR_RIGHT: begin
                nx  = x + COORD_W'(1);
                oob = (x == COORD_MAX);
            end
            DIR_DOWN: begin
                ny  = y + COORD_W'(1);
                oob = (y == COORD_MAX);
            end
            DIR_LEFT: begin
                nx  = x - COORD_W'(1);
                oob = (x == '0);
            end
            default: begin
                nx  = x;
                ny  = y;
            end
        endcase
    end

endmodule

// File: rtl/path_replayer.sv
// Replays a solved maze path: pops 2-bit direction codes from the queue, walks an
// (x,y) position from the latched origin and emits each new position on a
// valid/ready stream. Origin itself is never emitted.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start           : pulse; accepted only in IDLE/DONE, latches org_x/org_y
//   org_x, org_y    : replay origin
//   bus (master)    : queue pop (q_empty/q_data/q_deq) and position stream
//   steps           : moves applied since the last accepted start
//   busy / done     : replay running / replay finished
//   err             : sticky until next start; step limit reached or off-grid move
// Build option: define PATH_BOUNDS_CHECK_EN to block off-grid moves (position held,
// err set) instead of wrapping coordinates.
module path_replayer
    import maze_pkg::*;
#(
    parameter int unsigned COORD_W   = 4,
    parameter int unsigned MAX_STEPS = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [COORD_W-1:0]  org_x,
    input  logic [COORD_W-1:0]  org_y,
    path_replayer_if.master     bus,
    output logic [STEP_W-1:0]   steps,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

    replay_state_t      state_q, state_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic               pos_valid_q, pos_valid_d;
    logic               err_q, err_d;
    logic               q_deq_c;

    logic [COORD_W-1:0] step_nx_c, step_ny_c;
    logic               step_oob_c;

    // Next position computed straight from the queue's registered output in APPLY.
    pos_step #(
        .COORD_W (COORD_W)
    ) u_pos_step (
        .dir (dir_t'(bus.q_data)),
        .x   (pos_x_q),
        .y   (pos_y_q),
        .nx  (step_nx_c),
        .ny  (step_ny_c),
        .oob (step_oob_c)
    );

`ifndef PATH_BOUNDS_CHECK_EN
    logic step_oob_unused_c;
    assign step_oob_unused_c = step_oob_c;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            steps_q     <= '0;
            pos_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            steps_q     <= steps_d;
            pos_valid_q <= pos_valid_d;
            err_q       <= err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        steps_d     = steps_q;
        pos_valid_d = pos_valid_q;
        err_d       = err_q;
        q_deq_c     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = FETCH;
                    pos_x_d = org_x;
                    pos_y_d = org_y;
                    steps_d = '0;
                    err_d   = 1'b0;
                end
            end
            FETCH: begin
                // Pop is gated by q_empty so the queue is never underflowed.
                if (bus.q_empty) begin
                    state_d = DONE;
                end else begin
                    q_deq_c = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d = APPLY;
            end
            APPLY: begin
                steps_d     = steps_q + STEP_W'(1);
                pos_valid_d = 1'b1;
                state_d     = EMIT;
`ifdef PATH_BOUNDS_CHECK_EN
                if (step_oob_c) begin
                    err_d = 1'b1;
                end else begin
                    pos_x_d = step_nx_c;
                    pos_y_d = step_ny_c;
                end
`else
                pos_x_d = step_nx_c;
                pos_y_d = step_ny_c;
`endif
            end
            EMIT: begin
                if (bus.pos_ready) begin
                    pos_valid_d = 1'b0;
                    if (steps_q == STEP_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.q_deq     = q_deq_c;
    assign bus.pos_valid = pos_valid_q;
    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign steps         = steps_q;
    assign err           = err_q;
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);

endmodule
